// File: rtl/iq_write_ctrl.sv
// iq_write_ctrl: write-side controller for the dual-lane ID->IR instruction queue.
// Packs up to two decoded instructions onto the queue write lanes under a credit
// counter that mirrors the queue's free entries. Instructions that find no credit
// are parked in a 2-entry skid buffer, which then has priority over decode.

package iq_write_ctrl_pkg;
    localparam int INSTRUCTION_QUEUE_NUM_ENTRIES = 8;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] insn;
    } id_ir_stage_t;
endpackage

// state | meaning
// ------+---------------------------------------------------------------
// EMPTY | skid buffer empty; decode is the source when ready
// HOLD1 | one parked instruction in hold slot 0; decode stalled
// HOLD2 | two parked instructions, slot 0 older; decode stalled
module iq_write_ctrl
    import iq_write_ctrl_pkg::*;
#(
    parameter int NUM_ENTRIES = INSTRUCTION_QUEUE_NUM_ENTRIES,
    parameter int CW          = $clog2(NUM_ENTRIES) + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  id_ir_stage_t  dec_instr_i [2],
    input  logic [1:0]    dec_valid_i,
    output logic          dec_ready_o,
    output id_ir_stage_t  iq_instr_o  [2],
    output logic [1:0]    iq_write_o,
    input  logic [1:0]    iq_read_i,
    output logic [CW-1:0] credits_o,
    output logic          stall_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HOLD1 = 2'd1,
        HOLD2 = 2'd2
    } hold_state_e;

    localparam logic [CW-1:0] CREDITS_RST = CW'(NUM_ENTRIES);

    hold_state_e   state_q, state_d;
    logic [CW-1:0] credits_q, credits_d;
    id_ir_stage_t  hold_q [2];
    id_ir_stage_t  hold_d [2];

    id_ir_stage_t  slot [2];
    logic [1:0]    n_src;
    logic [1:0]    w;
    logic [1:0]    leftover;
    logic [1:0]    n_ret;

    // State register; hold data is don't-care after reset/flush so it is not reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= EMPTY;
            credits_q <= CREDITS_RST;
        end else begin
            state_q   <= state_d;
            credits_q <= credits_d;
        end
        hold_q <= hold_d;
    end

    // Output logic: pick the source, compact it toward lane 0, and size the write.
    always_comb begin
        dec_ready_o = ~rst_i & ~flush_i & (state_q == EMPTY);
        slot        = hold_q;
        n_src       = 2'd0;
        if (rst_i || flush_i) begin
            n_src = 2'd0;
        end else if (state_q == HOLD1) begin
            n_src = 2'd1;
        end else if (state_q == HOLD2) begin
            n_src = 2'd2;
        end else begin
            slot[0] = (dec_valid_i == 2'b10) ? dec_instr_i[1] : dec_instr_i[0];
            slot[1] = dec_instr_i[1];
            n_src   = {1'b0, dec_valid_i[0]} + {1'b0, dec_valid_i[1]};
        end
        // credits below n_src can only be 0 or 1, so the low two bits are exact
        w          = (CW'(n_src) > credits_q) ? credits_q[1:0] : n_src;
        iq_write_o = {w == 2'd2, w != 2'd0};
        iq_instr_o = slot;
        stall_o    = (n_src > w);
        credits_o  = credits_q;
    end

    // Next-state logic: park the unwritten tail and net writes against returns.
    always_comb begin
        leftover  = n_src - w;
        n_ret     = {1'b0, iq_read_i[0]} + {1'b0, iq_read_i[1]};
        hold_d    = hold_q;
        state_d   = EMPTY;
        credits_d = credits_q - CW'(w) + CW'(n_ret);
        if (rst_i || flush_i) begin
            state_d   = EMPTY;
            credits_d = CREDITS_RST;
        end else begin
            case (leftover)
                2'd1: begin
                    state_d   = HOLD1;
                    hold_d[0] = (w == 2'd0) ? slot[0] : slot[1];
                end
                2'd2: begin
                    state_d = HOLD2;
                    hold_d  = slot;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_iq_write_ctrl.sv
// Directed and random checks for iq_write_ctrl.
module tb_iq_write_ctrl;
    import iq_write_ctrl_pkg::*;

    localparam int N  = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst, flush;
    id_ir_stage_t  dec_instr [2];
    logic [1:0]    dec_valid;
    logic          dec_ready;
    id_ir_stage_t  iq_instr [2];
    logic [1:0]    iq_write;
    logic [1:0]    iq_read;
    logic [CW-1:0] credits;
    logic          stall;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    iq_write_ctrl #(.NUM_ENTRIES(N), .CW(CW)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .dec_instr_i(dec_instr), .dec_valid_i(dec_valid), .dec_ready_o(dec_ready),
        .iq_instr_o(iq_instr), .iq_write_o(iq_write), .iq_read_i(iq_read),
        .credits_o(credits), .stall_o(stall)
    );

    function automatic id_ir_stage_t mk(input int t);
        id_ir_stage_t r;
        r.pc   = 16'(t * 4);
        r.insn = 16'(16'hA000 + t);
        return r;
    endfunction

    task automatic drive(input logic [1:0] v, input int ta, input int tb,
                         input logic [1:0] rd, input logic fl, input logic r);
        dec_valid    = v;
        dec_instr[0] = mk(ta);
        dec_instr[1] = mk(tb);
        iq_read      = rd;
        flush        = fl;
        rst          = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(2'b11, 900, 901, 2'b00, 1'b0, 1'b1);
        @(negedge clk);
        n_cmp++; if (iq_write !== 2'b00) begin n_bad++; $display("FAIL rst_write: got %b want 00", iq_write); end
        n_cmp++; if (dec_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", dec_ready); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", stall); end
        tick();
        @(negedge clk);
        n_cmp++; if (credits !== 4'd8) begin n_bad++; $display("FAIL rst_credits: got %0d want 8", credits); end
        tick();
    endtask

    task automatic test_dual_write();
        drive(2'b11, 1, 2, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++; if (iq_write !== 2'b11) begin n_bad++; $display("FAIL dual_write: got %b want 11", iq_write); end
        n_cmp++; if (iq_instr[0] !== mk(1)) begin n_bad++; $display("FAIL dual_lane0: got %h want %h", iq_instr[0], mk(1)); end
        n_cmp++; if (iq_instr[1] !== mk(2)) begin n_bad++; $display("FAIL dual_lane1: got %h want %h", iq_instr[1], mk(2)); end
        n_cmp++; if (dec_ready !== 1'b1 || stall !== 1'b0) begin n_bad++; $display("FAIL dual_hs: ready=%b stall=%b want 1/0", dec_ready, stall); end
        tick();
        drive(2'b00, 0, 0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++; if (credits !== 4'd6) begin n_bad++; $display("FAIL dual_credits: got %0d want 6", credits); end
        tick();
    endtask

    task automatic test_lane1_only();
        drive(2'b10, 99, 3, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++; if (iq_write !== 2'b01) begin n_bad++; $display("FAIL l1_write: got %b want 01", iq_write); end
        n_cmp++; if (iq_instr[0] !== mk(3)) begin n_bad++; $display("FAIL l1_slot0: got %h want %h", iq_instr[0], mk(3)); end
        tick();
        drive(2'b00, 0, 0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++; if (credits !== 4'd5) begin n_bad++; $display("FAIL l1_credits: got %0d want 5", credits); end
        tick();
    endtask

    task automatic test_credit_shortfall();
        drive(2'b11, 4, 5, 2'b00, 1'b0, 1'b0); tick();
        drive(2'b11, 6, 7, 2'b00, 1'b0, 1'b0); tick();
        drive(2'b11, 8, 9, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++; if (credits !== 4'd1) begin n_bad++; $display("FAIL sf0_credits: got %0d want 1", credits); end
        n_cmp++; if (iq_write !== 2'b01 || iq_instr[0] !== mk(8)) begin n_bad++; $display("FAIL sf0_write: got %b/%h want 01/%h", iq_write, iq_instr[0], mk(8)); end
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL sf0_stall: got %b want 1", stall); end
        tick();
        drive(2'b11, 50, 51, 2'b01, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++; if (dec_ready !== 1'b0) begin n_bad++; $display("FAIL sf1_ready: got %b want 0", dec_ready); end
        n_cmp++; if (credits !== 4'd0) begin n_bad++; $display("FAIL sf1_credits: got %0d want 0", credits); end
        n_cmp++; if (iq_write !== 2'b00 || stall !== 1'b1) begin n_bad++; $display("FAIL sf1_write: got %b/%b want 00/1", iq_write, stall); end
        tick();
        drive(2'b00, 0, 0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++; if (credits !== 4'd1) begin n_bad++; $display("FAIL sf2_credits: got %0d want 1", credits); end
        n_cmp++; if (iq_write !== 2'b01 || iq_instr[0] !== mk(9)) begin n_bad++; $display("FAIL sf2_write: got %b/%h want 01/%h", iq_write, iq_instr[0], mk(9)); end
        n_cmp++; if (stall !== 1'b0 || dec_ready !== 1'b0) begin n_bad++; $display("FAIL sf2_hs: stall=%b ready=%b want 0/0", stall, dec_ready); end
        tick();
        @(negedge clk);
        n_cmp++; if (dec_ready !== 1'b1 || credits !== 4'd0) begin n_bad++; $display("FAIL sf3: ready=%b credits=%0d want 1/0", dec_ready, credits); end
        tick();
    endtask

    task automatic test_hold2_drain();
        drive(2'b11, 10, 11, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++; if (iq_write !== 2'b00 || stall !== 1'b1) begin n_bad++; $display("FAIL h2_park: write=%b stall=%b want 00/1", iq_write, stall); end
        tick();
        drive(2'b00, 0, 0, 2'b11, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++; if (dec_ready !== 1'b0 || iq_write !== 2'b00 || credits !== 4'd0) begin n_bad++; $display("FAIL h2_wait: ready=%b write=%b credits=%0d want 0/00/0", dec_ready, iq_write, credits); end
        tick();
        drive(2'b00, 0, 0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++; if (credits !== 4'd2) begin n_bad++; $display("FAIL h2_credits: got %0d want 2", credits); end
        n_cmp++; if (iq_write !== 2'b11 || iq_instr[0] !== mk(10) || iq_instr[1] !== mk(11)) begin n_bad++; $display("FAIL h2_write: got %b %h %h want 11 %h %h", iq_write, iq_instr[0], iq_instr[1], mk(10), mk(11)); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL h2_stall: got %b want 0", stall); end
        tick();
        @(negedge clk);
        n_cmp++; if (credits !== 4'd0 || dec_ready !== 1'b1) begin n_bad++; $display("FAIL h2_after: credits=%0d ready=%b want 0/1", credits, dec_ready); end
        tick();
    endtask

    task automatic test_flush();
        drive(2'b11, 12, 13, 2'b00, 1'b0, 1'b0); tick();
        drive(2'b00, 0, 0, 2'b11, 1'b1, 1'b0);
        @(negedge clk);
        n_cmp++; if (iq_write !== 2'b00 || dec_ready !== 1'b0) begin n_bad++; $display("FAIL fl_cycle: write=%b ready=%b want 00/0", iq_write, dec_ready); end
        tick();
        drive(2'b00, 0, 0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++; if (credits !== 4'd8) begin n_bad++; $display("FAIL fl_credits: got %0d want 8", credits); end
        n_cmp++; if (dec_ready !== 1'b1 || iq_write !== 2'b00) begin n_bad++; $display("FAIL fl_after: ready=%b write=%b want 1/00", dec_ready, iq_write); end
        tick();
    endtask

    task automatic test_write_and_return();
        drive(2'b11, 14, 15, 2'b00, 1'b0, 1'b0); tick();
        drive(2'b11, 16, 17, 2'b01, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++; if (credits !== 4'd6 || iq_write !== 2'b11) begin n_bad++; $display("FAIL wr_ret0: credits=%0d write=%b want 6/11", credits, iq_write); end
        tick();
        drive(2'b00, 0, 0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++; if (credits !== 4'd5) begin n_bad++; $display("FAIL wr_ret1: got %0d want 5", credits); end
        tick();
    endtask

    task automatic test_reset_mid();
        drive(2'b11, 18, 19, 2'b00, 1'b0, 1'b0); tick();
        drive(2'b11, 20, 21, 2'b00, 1'b0, 1'b0); tick();
        drive(2'b11, 22, 23, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++; if (iq_write !== 2'b01 || stall !== 1'b1) begin n_bad++; $display("FAIL rm_park: write=%b stall=%b want 01/1", iq_write, stall); end
        tick();
        drive(2'b00, 0, 0, 2'b00, 1'b0, 1'b1);
        @(negedge clk);
        n_cmp++; if (iq_write !== 2'b00 || dec_ready !== 1'b0 || stall !== 1'b0) begin n_bad++; $display("FAIL rm_rst: write=%b ready=%b stall=%b want 00/0/0", iq_write, dec_ready, stall); end
        tick();
        drive(2'b00, 0, 0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++; if (credits !== 4'd8 || dec_ready !== 1'b1 || iq_write !== 2'b00) begin n_bad++; $display("FAIL rm_after: credits=%0d ready=%b write=%b want 8/1/00", credits, dec_ready, iq_write); end
        tick();
    endtask

    task automatic test_random_traffic();
        id_ir_stage_t exp_q [$];
        id_ir_stage_t e;
        int occ = 0;
        int tag = 1000;
        int r, w, cyc;
        logic [1:0] v, rd;
        cyc = 0;
        while (cyc < 10000 || ((exp_q.size() != 0 || occ != 0) && cyc < 10200)) begin
            v = (cyc < 10000) ? 2'($urandom_range(0, 3)) : 2'b00;
            r = (cyc < 10000) ? $urandom_range(0, (occ < 2) ? occ : 2) : ((occ < 2) ? occ : 2);
            rd = (r == 2) ? 2'b11 : (r == 1) ? 2'b01 : 2'b00;
            drive(v, tag, tag + 1, rd, 1'b0, 1'b0);
            @(negedge clk);
            n_cmp++; if (credits !== CW'(N - occ)) begin n_bad++; $display("FAIL rnd_credits cyc %0d: got %0d want %0d", cyc, credits, N - occ); end
            if (dec_ready === 1'b1) begin
                if (v[0]) exp_q.push_back(mk(tag));
                if (v[1]) exp_q.push_back(mk(tag + 1));
            end
            n_cmp++; if (iq_write === 2'b10) begin n_bad++; $display("FAIL rnd_strobe cyc %0d: got 10 want 00/01/11", cyc); end
            w = 0;
            for (int k = 0; k < 2; k++) begin
                if (iq_write[k] === 1'b1) begin
                    w++;
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++; $display("FAIL rnd_spurious cyc %0d lane %0d: got %h want no write", cyc, k, iq_instr[k]);
                    end else begin
                        e = exp_q.pop_front();
                        if (iq_instr[k] !== e) begin n_bad++; $display("FAIL rnd_order cyc %0d lane %0d: got %h want %h", cyc, k, iq_instr[k], e); end
                    end
                end
            end
            occ = occ + w - r;
            n_cmp++; if (occ > N) begin n_bad++; $display("FAIL rnd_overflow cyc %0d: occupancy %0d want <= %0d", cyc, occ, N); end
            tag += 2;
            cyc++;
            tick();
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rnd_loss: %0d undelivered want 0", exp_q.size()); end
        drive(2'b00, 0, 0, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        n_cmp++; if (credits !== 4'd8) begin n_bad++; $display("FAIL rnd_final_credits: got %0d want 8", credits); end
        tick();
    endtask

    initial begin
        test_reset();
        test_dual_write();
        test_lane1_only();
        test_credit_shortfall();
        test_hold2_drain();
        test_flush();
        test_write_and_return();
        test_reset_mid();
        test_random_traffic();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
